// File: rtl/fanin_gather_pkg.sv
// fanin_gather_pkg: shared constants and types for the fan-in gather block.
//   NUM_SRC_DEF : default number of one-bit sources
//   idx_w()     : index width derivation (clog2, minimum 1)
//   IDX_W_DEF   : index width for the default source count
//   rec_t       : output record {idx, dat}
package fanin_gather_pkg;

  localparam int NUM_SRC_DEF = 35;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int IDX_W_DEF = idx_w(NUM_SRC_DEF);

  // Sized for the default source count; widen IDX_W_DEF if NUM_SRC grows
  // past 2**IDX_W_DEF.
  typedef struct packed {
    logic [IDX_W_DEF-1:0] idx;
    logic                 dat;
  } rec_t;

endpackage

// File: rtl/fanin_rr_arb.sv
// fanin_rr_arb: combinational round-robin search.
//   i_req : request vector (one bit per source)
//   i_ptr : last granted index; search starts at i_ptr+1 and wraps
//   o_any : at least one request set
//   o_win : first requesting index at or after i_ptr+1 (mod NUM_SRC)
module fanin_rr_arb
  import fanin_gather_pkg::*;
#(
  parameter int NUM_SRC = NUM_SRC_DEF,
  parameter int IDX_W   = idx_w(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic               o_any,
  output logic [IDX_W-1:0]   o_win
);

  // w_cand[g] is the index visited at search step g: (ptr + 1 + g) mod NUM_SRC.
  // ptr < NUM_SRC and g+1 <= NUM_SRC, so one conditional subtract suffices.
  logic [NUM_SRC-1:0][IDX_W-1:0] w_cand;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_cand
    logic [IDX_W:0] w_sum;
    assign w_sum = {1'b0, i_ptr} + (IDX_W+1)'(g + 1);
    assign w_cand[g] = (w_sum >= (IDX_W+1)'(NUM_SRC)) ?
                       IDX_W'(w_sum - (IDX_W+1)'(NUM_SRC)) : IDX_W'(w_sum);
  end

  assign o_any = |i_req;

  // Walk from the farthest step back to the nearest so the nearest hit wins.
  always_comb begin
    o_win = '0;
    for (int g = NUM_SRC - 1; g >= 0; g--) begin
      if (i_req[w_cand[g]]) o_win = w_cand[g];
    end
  end

endmodule

// File: rtl/fanin_gather.sv
// fanin_gather: gathers one-cycle events from NUM_SRC one-bit sources into a
// single registered valid/ready record stream, round-robin between sources.
// Each source holds at most one pending event; a second event arriving while
// one is pending (and not being granted that cycle) is dropped.
//   clk1    : clock, rising edge
//   rst     : asynchronous active-high reset
//   src_vld : per-source capture strobe
//   src_dat : per-source data bit, sampled with src_vld
//   out_vld : record valid (registered)
//   out_rdy : downstream accept
//   out_idx : granted source index
//   out_dat : captured data bit of the granted source
//   busy    : any event pending or a record presented
//   ovf     : sticky drop flag, present only when FANIN_GATHER_OVF_EN is defined
module fanin_gather
  import fanin_gather_pkg::*;
#(
  parameter int NUM_SRC = NUM_SRC_DEF,
  parameter int IDX_W   = idx_w(NUM_SRC)
) (
  input  logic               clk1,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] src_vld,
  input  logic [NUM_SRC-1:0] src_dat,
  output logic               out_vld,
  input  logic               out_rdy,
  output logic [IDX_W-1:0]   out_idx,
  output logic               out_dat,
  output logic               busy
`ifdef FANIN_GATHER_OVF_EN
  ,
  output logic               ovf
`endif
);

  logic [NUM_SRC-1:0] r_pend;
  logic [NUM_SRC-1:0] r_hold;
  logic [IDX_W-1:0]   r_ptr;
  logic               r_out_vld;
  rec_t               r_out;

  logic               w_any;
  logic [IDX_W-1:0]   w_win;
  logic               w_free;
  logic               w_grant;
  logic [NUM_SRC-1:0] w_gnt_vec;
  logic [NUM_SRC-1:0] w_cap;

  fanin_rr_arb #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (IDX_W)
  ) u_arb (
    .i_req (r_pend),
    .i_ptr (r_ptr),
    .o_any (w_any),
    .o_win (w_win)
  );

  assign w_free    = !r_out_vld || out_rdy;
  assign w_grant   = w_free && w_any;
  assign w_gnt_vec = w_grant ? (NUM_SRC'(1) << w_win) : '0;

  // A slot is open for capture if it is empty or being granted this edge,
  // so an event landing on its own grant edge is kept, not lost.
  assign w_cap = src_vld & (~r_pend | w_gnt_vec);

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      r_pend <= '0;
      r_hold <= '0;
    end else begin
      r_pend <= (r_pend & ~w_gnt_vec) | w_cap;
      r_hold <= (r_hold & ~w_cap) | (src_dat & w_cap);
    end
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      r_out_vld <= 1'b0;
      r_out     <= '0;
      r_ptr     <= IDX_W'(NUM_SRC - 1);  // first search lands on index 0
    end else if (w_grant) begin
      r_out_vld <= 1'b1;
      r_out.idx <= IDX_W_DEF'(w_win);
      r_out.dat <= r_hold[w_win];
      r_ptr     <= w_win;
    end else if (w_free) begin
      r_out_vld <= 1'b0;
    end
  end

  assign out_vld = r_out_vld;
  assign out_idx = IDX_W'(r_out.idx);
  assign out_dat = r_out.dat;
  assign busy    = (|r_pend) || r_out_vld;

`ifdef FANIN_GATHER_OVF_EN
  logic               r_ovf;
  logic [NUM_SRC-1:0] w_drop;

  assign w_drop = src_vld & r_pend & ~w_gnt_vec;

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst)          r_ovf <= 1'b0;
    else if (|w_drop) r_ovf <= 1'b1;
  end

  assign ovf = r_ovf;
`endif

endmodule

// File: doc/fanin_gather.md
FANIN_GATHER -- requirements
Module: fanin_gather

Interface
REQ-001 Parameter NUM_SRC SHALL be: NUM_SRC, default 35, number of one-bit sources converging on the block.
REQ-002 Parameter IDX_W SHALL be: IDX_W, default $clog2(NUM_SRC) = 6, width of the source index.
REQ-003 Port clk1 SHALL be: clk1  input  1  sole clock; all state updates on rising edge.
REQ-004 Port rst SHALL be: rst  input  1  asynchronous, active-high reset.
REQ-005 Port src_vld SHALL be: src_vld  input  NUM_SRC  per-source capture strobe, one cycle per event.
REQ-006 Port src_dat SHALL be: src_dat  input  NUM_SRC  per-source data bit, sampled with src_vld.
REQ-007 Port out_vld SHALL be: out_vld  output  1  registered output record valid.
REQ-008 Port out_rdy SHALL be: out_rdy  input  1  downstream accept.
REQ-009 Port out_idx SHALL be: out_idx  output  IDX_W  index of granted source.
REQ-010 Port out_dat SHALL be: out_dat  output  1  captured data bit of granted source.
REQ-011 Port busy SHALL be: busy  output  1  OR of all pending bits and out_vld.
REQ-012 Port ovf SHALL be: ovf  output  1  sticky overflow flag (present only with FANIN_GATHER_OVF_EN).

Function
REQ-013 Per source i: pend[i] and hold[i] registers; src_vld[i] & !pend[i] SHALL set pend[i] and load hold[i] <= src_dat[i] next edge.
REQ-014 Output slot is free when !out_vld or (out_vld & out_rdy); handshake completes on out_vld & out_rdy.
REQ-015 When slot free and any pend set, round-robin winner SHALL be the first set pend index searching upward from ptr+1, wrapping NUM_SRC-1 -> 0.
REQ-016 On grant: out_vld<=1, out_idx<=win, out_dat<=hold[win], pend[win]<=0, ptr<=win, same edge.
REQ-017 Slot free and no pend set: out_vld SHALL go 0 next edge.
REQ-018 While out_vld & !out_rdy, out_idx/out_dat SHALL stay stable; no grant.
REQ-019 Latency: src_vld at edge t -> pend at t+1 -> out_vld earliest at t+2; back-to-back grants SHALL sustain one record per cycle with out_rdy held 1.
REQ-020 Grant uses registered pend; a source captured this cycle SHALL not be granted this cycle.
REQ-021 src_vld[i] on the cycle pend[i] is cleared by grant: new event SHALL be captured (pend[i] stays 1, hold[i] updated).
REQ-022 src_vld[i] while pend[i]=1 and not granted that cycle: event SHALL be dropped, hold[i] unchanged.
REQ-023 Fairness: with all sources pending, each index SHALL be granted exactly once per NUM_SRC grants.

Reset
REQ-024 rst SHALL asynchronously clear pend, hold, out_vld, out_idx, out_dat, ovf to 0 and set ptr to NUM_SRC-1 (first search starts at 0).
REQ-025 rst mid-transfer SHALL discard the presented record and all pending events; no output until new src_vld after release.

Configuration
REQ-026 Macro FANIN_GATHER_OVF_EN defined: ovf port present, set on any REQ-022 drop, cleared only by rst.
REQ-027 Macro undefined: ovf port and logic absent; drops silent; all else identical.

Structure
REQ-028 Package fanin_gather_pkg SHALL hold NUM_SRC default, IDX_W derivation, and the output record typedef (idx, dat).
REQ-029 Round-robin search SHALL be sub-module fanin_rr_arb (inputs req vector, ptr; outputs any, win index); pend/hold/output regs stay in fanin_gather.

Verification
REQ-030 Single event: src_vld[5]=1,src_dat[5]=1 at t, out_rdy=1 -> out_vld=1,out_idx=5,out_dat=1 at t+2, out_vld=0 at t+3.
REQ-031 Burst: all 35 src_vld=1 one cycle, src_dat=i&1, out_rdy=1 -> 35 consecutive records idx 0..34, dat alternating 0,1; busy falls after last.
REQ-032 Backpressure: idx 3 and 7 pending, out_rdy=0 for 4 cycles -> idx 3 held stable 4 cycles, then 3 and 7 in consecutive cycles.
REQ-033 Overflow (OVF_EN): out_rdy=0, src_vld[2] twice with dat 1 then 0 -> out_dat=1 for idx 2, ovf=1; without macro no ovf port, same record.
REQ-034 Capture-on-grant: src_vld[9] on grant edge of idx 9 with dat=0 -> second record idx 9 dat 0, ovf stays 0.
REQ-035 Reset mid-op: rst pulse while out_vld=1 and 10 pending -> out_vld=0, busy=0 immediately; next event at idx 0 granted first.
